// File: rtl/control_unit.sv
// control_unit: multi-cycle sequencer for the single-issue CPU datapath.
// Fetches an instruction over the shared RAM port, decodes it and drives the
// datapath controls one instruction at a time. It also owns the RAM handshake
// and aborts to HALT when a request waits too long for mem_ready.
module control_unit #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        mem_ready,
    input  logic [31:0] instr_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_sel,
    output logic [5:0]  opcode,
    output logic [4:0]  op1,
    output logic [4:0]  op2,
    output logic [15:0] imm,
    output logic [4:0]  alucode,
    output logic        imControl,
    output logic        regenable,
    output logic        ramenable,
    output logic [1:0]  pcControl,
    output logic [1:0]  writecode,
    output logic        halted,
    output logic        illegal,
    output logic        bus_error,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    // The request times out on the edge where the wait counter already holds
    // MEM_TIMEOUT-1 and mem_ready is still low, i.e. after MEM_TIMEOUT cycles.
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      cur_state;
    state_t      next_state;
    logic [31:0] ir;
    logic [7:0]  wait_count;
    logic        timeout_hit;

    logic is_alu_rr;
    logic is_alu_imm;
    logic is_alu;
    logic is_load;
    logic is_store;
    logic is_beq;
    logic is_jump;
    logic is_loadi;
    logic is_halt;
    logic is_known;

    assign opcode = ir[31:26];
    assign op1    = ir[25:21];
    assign op2    = ir[20:16];
    assign imm    = ir[15:0];
    assign state  = cur_state;

    assign is_alu_rr  = (opcode <= 6'h0B);
    assign is_alu_imm = (opcode >= 6'h10) && (opcode <= 6'h1B);
    assign is_alu     = is_alu_rr || is_alu_imm;
    assign is_load    = (opcode == 6'h20);
    assign is_store   = (opcode == 6'h21);
    assign is_beq     = (opcode == 6'h22);
    assign is_jump    = (opcode == 6'h23);
    assign is_loadi   = (opcode == 6'h24);
    assign is_halt    = (opcode == 6'h3F);
    assign is_known   = is_alu || is_load || is_store || is_beq || is_jump
                        || is_loadi || is_halt;

    // State, instruction register, wait counter and sticky status flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            cur_state  <= S_FETCH;
            ir         <= 32'h0;
            wait_count <= 8'h0;
            illegal    <= 1'b0;
            bus_error  <= 1'b0;
        end else begin
            cur_state <= next_state;
            if (cur_state == S_FETCH && mem_req && mem_ready)
                ir <= instr_in;
            if (mem_req && !mem_ready && !timeout_hit)
                wait_count <= wait_count + 8'd1;
            else
                wait_count <= 8'h0;
            if (cur_state == S_DECODE && !is_known)
                illegal <= 1'b1;
            if (timeout_hit)
                bus_error <= 1'b1;
        end
    end

    // Next-state and Moore control outputs; a nonzero wait counter in FETCH
    // keeps an already issued fetch alive even if run drops mid-request.
    always_comb begin
        next_state  = cur_state;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_sel     = 1'b0;
        alucode     = 5'd0;
        imControl   = 1'b0;
        regenable   = 1'b0;
        ramenable   = 1'b0;
        pcControl   = 2'd3;
        writecode   = 2'd0;
        halted      = 1'b0;
        timeout_hit = 1'b0;

        if (is_alu && (cur_state == S_DECODE || cur_state == S_EXECUTE ||
                       cur_state == S_MEM || cur_state == S_WRITEBACK)) begin
            alucode   = {1'b0, opcode[3:0]};
            imControl = is_alu_imm;
        end

        case (cur_state)
            S_FETCH: begin
                mem_req = run || (wait_count != 8'h0);
                if (mem_req) begin
                    if (mem_ready) begin
                        next_state = S_DECODE;
                    end else if (wait_count == TIMEOUT_LAST) begin
                        timeout_hit = 1'b1;
                        next_state  = S_HALT;
                    end
                end
            end
            S_DECODE: begin
                if (!is_known || is_halt)
                    next_state = S_HALT;
                else
                    next_state = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (is_beq) begin
                    pcControl  = 2'd1;
                    next_state = S_FETCH;
                end else if (is_jump) begin
                    pcControl  = 2'd2;
                    next_state = S_FETCH;
                end else if (is_load || is_store) begin
                    next_state = S_MEM;
                end else begin
                    next_state = S_WRITEBACK;
                end
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_sel   = 1'b1;
                ramenable = 1'b1;
                mem_we    = is_store;
                if (mem_ready) begin
                    next_state = S_WRITEBACK;
                end else if (wait_count == TIMEOUT_LAST) begin
                    timeout_hit = 1'b1;
                    next_state  = S_HALT;
                end
            end
            S_WRITEBACK: begin
                pcControl  = 2'd0;
                regenable  = is_alu || is_load || is_loadi;
                if (is_load)
                    writecode = 2'd1;
                else if (is_loadi)
                    writecode = 2'd2;
                next_state = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                next_state = S_HALT;
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed vector table for the per-cycle control outputs of
// several instruction classes, plus hand-written sequences for halt, illegal
// opcodes, RAM timeout and reset in the middle of a data access.
module tb_control_unit;

    localparam logic [31:0] I_ADD   = 32'h0422_0000;  // op 01, r1, r2
    localparam logic [31:0] I_LDI   = 32'h9060_1234;  // op 24
    localparam logic [31:0] I_ALUI  = 32'h4C00_0000;  // op 13
    localparam logic [31:0] I_LOAD  = 32'h8080_0040;  // op 20
    localparam logic [31:0] I_STORE = 32'h8400_0040;  // op 21
    localparam logic [31:0] I_BEQ   = 32'h8800_0000;  // op 22
    localparam logic [31:0] I_JUMP  = 32'h8C00_0010;  // op 23
    localparam logic [31:0] I_OPB   = 32'h2C00_0000;  // op 0B
    localparam logic [31:0] I_HALT  = 32'hFC22_ABCD;  // op 3F
    localparam logic [31:0] I_ILL30 = 32'hC000_0000;  // op 30
    localparam logic [31:0] I_ILL0C = 32'h3000_0000;  // op 0C

    logic        clock;
    logic        reset;
    logic        run;
    logic        mem_ready;
    logic [31:0] instr_in;
    logic        mem_req;
    logic        mem_we;
    logic        mem_sel;
    logic [5:0]  opcode;
    logic [4:0]  op1;
    logic [4:0]  op2;
    logic [15:0] imm;
    logic [4:0]  alucode;
    logic        imControl;
    logic        regenable;
    logic        ramenable;
    logic [1:0]  pcControl;
    logic [1:0]  writecode;
    logic        halted;
    logic        illegal;
    logic        bus_error;
    logic [2:0]  state;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        run;
        logic        rdy;
        logic [31:0] instr;
        logic [2:0]  st;
        logic        req;
        logic        we;
        logic        sel;
        logic        ram;
        logic [1:0]  pc;
        logic        reg_en;
        logic [1:0]  wc;
        logic [4:0]  alu;
        logic        imc;
    } vec_t;

    vec_t vecs[$];

    control_unit #(.MEM_TIMEOUT(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .run       (run),
        .mem_ready (mem_ready),
        .instr_in  (instr_in),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_sel   (mem_sel),
        .opcode    (opcode),
        .op1       (op1),
        .op2       (op2),
        .imm       (imm),
        .alucode   (alucode),
        .imControl (imControl),
        .regenable (regenable),
        .ramenable (ramenable),
        .pcControl (pcControl),
        .writecode (writecode),
        .halted    (halted),
        .illegal   (illegal),
        .bus_error (bus_error),
        .state     (state)
    );

    // Free-running 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] ins,
                                input logic [2:0] st, input logic req, input logic we,
                                input logic sel, input logic ram, input logic [1:0] pc,
                                input logic reg_en, input logic [1:0] wc,
                                input logic [4:0] alu, input logic imc);
        vec_t v;
        v.run = r;    v.rdy = rd;   v.instr = ins; v.st = st;
        v.req = req;  v.we = we;    v.sel = sel;   v.ram = ram;
        v.pc = pc;    v.reg_en = reg_en; v.wc = wc; v.alu = alu; v.imc = imc;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        run       = v.run;
        mem_ready = v.rdy;
        instr_in  = v.instr;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyReset(input string tag);
        reset     = 1'b1;
        run       = 1'b0;
        mem_ready = 1'b0;
        tick();
        checkOutput({tag, ".state"}, 32'(state), 32'd0);
        checkOutput({tag, ".mem_req"}, 32'(mem_req), 32'd0);
        checkOutput({tag, ".pcControl"}, 32'(pcControl), 32'd3);
        checkOutput({tag, ".halted"}, 32'(halted), 32'd0);
        checkOutput({tag, ".illegal"}, 32'(illegal), 32'd0);
        checkOutput({tag, ".bus_error"}, 32'(bus_error), 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        run       = 1'b0;
        mem_ready = 1'b0;
        instr_in  = 32'h0;

        // run rdy instr   st req we sel ram pc reg wc alu imc
        vecs.push_back(mk(1, 1, I_ADD,   0, 1, 0, 0, 0, 3, 0, 0, 0,  0));
        vecs.push_back(mk(1, 1, I_ADD,   1, 0, 0, 0, 0, 3, 0, 0, 1,  0));
        vecs.push_back(mk(1, 1, I_ADD,   2, 0, 0, 0, 0, 3, 0, 0, 1,  0));
        vecs.push_back(mk(1, 1, I_ADD,   4, 0, 0, 0, 0, 0, 1, 0, 1,  0));
        vecs.push_back(mk(1, 1, I_LDI,   0, 1, 0, 0, 0, 3, 0, 0, 0,  0));
        vecs.push_back(mk(1, 1, I_LDI,   1, 0, 0, 0, 0, 3, 0, 0, 0,  0));
        vecs.push_back(mk(1, 1, I_LDI,   2, 0, 0, 0, 0, 3, 0, 0, 0,  0));
        vecs.push_back(mk(1, 1, I_LDI,   4, 0, 0, 0, 0, 0, 1, 2, 0,  0));
        vecs.push_back(mk(1, 1, I_ALUI,  0, 1, 0, 0, 0, 3, 0, 0, 0,  0));
        vecs.push_back(mk(1, 1, I_ALUI,  1, 0, 0, 0, 0, 3, 0, 0, 3,  1));
        vecs.push_back(mk(1, 1, I_ALUI,  2, 0, 0, 0, 0, 3, 0, 0, 3,  1));
        vecs.push_back(mk(1, 1, I_ALUI,  4, 0, 0, 0, 0, 0, 1, 0, 3,  1));
        vecs.push_back(mk(1, 1, I_LOAD,  0, 1, 0, 0, 0, 3, 0, 0, 0,  0));
        vecs.push_back(mk(1, 0, I_LOAD,  1, 0, 0, 0, 0, 3, 0, 0, 0,  0));
        vecs.push_back(mk(1, 0, I_LOAD,  2, 0, 0, 0, 0, 3, 0, 0, 0,  0));
        vecs.push_back(mk(1, 0, I_LOAD,  3, 1, 0, 1, 1, 3, 0, 0, 0,  0));
        vecs.push_back(mk(1, 0, I_LOAD,  3, 1, 0, 1, 1, 3, 0, 0, 0,  0));
        vecs.push_back(mk(1, 0, I_LOAD,  3, 1, 0, 1, 1, 3, 0, 0, 0,  0));
        vecs.push_back(mk(1, 1, I_LOAD,  3, 1, 0, 1, 1, 3, 0, 0, 0,  0));
        vecs.push_back(mk(1, 1, I_LOAD,  4, 0, 0, 0, 0, 0, 1, 1, 0,  0));
        vecs.push_back(mk(1, 1, I_STORE, 0, 1, 0, 0, 0, 3, 0, 0, 0,  0));
        vecs.push_back(mk(1, 1, I_STORE, 1, 0, 0, 0, 0, 3, 0, 0, 0,  0));
        vecs.push_back(mk(1, 1, I_STORE, 2, 0, 0, 0, 0, 3, 0, 0, 0,  0));
        vecs.push_back(mk(1, 1, I_STORE, 3, 1, 1, 1, 1, 3, 0, 0, 0,  0));
        vecs.push_back(mk(1, 1, I_STORE, 4, 0, 0, 0, 0, 0, 0, 0, 0,  0));
        vecs.push_back(mk(1, 1, I_BEQ,   0, 1, 0, 0, 0, 3, 0, 0, 0,  0));
        vecs.push_back(mk(1, 1, I_BEQ,   1, 0, 0, 0, 0, 3, 0, 0, 0,  0));
        vecs.push_back(mk(1, 1, I_BEQ,   2, 0, 0, 0, 0, 1, 0, 0, 0,  0));
        vecs.push_back(mk(1, 1, I_JUMP,  0, 1, 0, 0, 0, 3, 0, 0, 0,  0));
        vecs.push_back(mk(1, 1, I_JUMP,  1, 0, 0, 0, 0, 3, 0, 0, 0,  0));
        vecs.push_back(mk(1, 1, I_JUMP,  2, 0, 0, 0, 0, 2, 0, 0, 0,  0));
        vecs.push_back(mk(1, 0, I_OPB,   0, 1, 0, 0, 0, 3, 0, 0, 0,  0));
        vecs.push_back(mk(0, 0, I_OPB,   0, 1, 0, 0, 0, 3, 0, 0, 0,  0));
        vecs.push_back(mk(0, 1, I_OPB,   0, 1, 0, 0, 0, 3, 0, 0, 0,  0));
        vecs.push_back(mk(0, 0, I_OPB,   1, 0, 0, 0, 0, 3, 0, 0, 11, 0));
        vecs.push_back(mk(0, 0, I_OPB,   2, 0, 0, 0, 0, 3, 0, 0, 11, 0));
        vecs.push_back(mk(0, 0, I_OPB,   4, 0, 0, 0, 0, 0, 1, 0, 11, 0));
        vecs.push_back(mk(0, 0, I_OPB,   0, 0, 0, 0, 0, 3, 0, 0, 0,  0));
        vecs.push_back(mk(0, 0, I_OPB,   0, 0, 0, 0, 0, 3, 0, 0, 0,  0));

        tick();
        applyReset("reset");
        checkOutput("reset.opcode", 32'(opcode), 32'd0);
        checkOutput("reset.imm", 32'(imm), 32'd0);
        checkOutput("reset.regenable", 32'(regenable), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("row%0d.state", i), 32'(state), 32'(vecs[i].st));
            checkOutput($sformatf("row%0d.mem_req", i), 32'(mem_req), 32'(vecs[i].req));
            checkOutput($sformatf("row%0d.mem_we", i), 32'(mem_we), 32'(vecs[i].we));
            checkOutput($sformatf("row%0d.mem_sel", i), 32'(mem_sel), 32'(vecs[i].sel));
            checkOutput($sformatf("row%0d.ramenable", i), 32'(ramenable), 32'(vecs[i].ram));
            checkOutput($sformatf("row%0d.pcControl", i), 32'(pcControl), 32'(vecs[i].pc));
            checkOutput($sformatf("row%0d.regenable", i), 32'(regenable), 32'(vecs[i].reg_en));
            checkOutput($sformatf("row%0d.writecode", i), 32'(writecode), 32'(vecs[i].wc));
            checkOutput($sformatf("row%0d.alucode", i), 32'(alucode), 32'(vecs[i].alu));
            checkOutput($sformatf("row%0d.imControl", i), 32'(imControl), 32'(vecs[i].imc));
            checkOutput($sformatf("row%0d.halted", i), 32'(halted), 32'd0);
            tick();
        end

        // HALT opcode: DECODE then straight to HALT, terminal.
        run = 1'b1; mem_ready = 1'b1; instr_in = I_HALT;
        tick();
        checkOutput("halt.dec_state", 32'(state), 32'd1);
        checkOutput("halt.opcode", 32'(opcode), 32'h3F);
        checkOutput("halt.op1", 32'(op1), 32'd1);
        checkOutput("halt.op2", 32'(op2), 32'd2);
        checkOutput("halt.imm", 32'(imm), 32'hABCD);
        tick();
        checkOutput("halt.state", 32'(state), 32'd5);
        checkOutput("halt.halted", 32'(halted), 32'd1);
        checkOutput("halt.illegal", 32'(illegal), 32'd0);
        checkOutput("halt.pcControl", 32'(pcControl), 32'd3);
        repeat (3) tick();
        checkOutput("halt.stay_state", 32'(state), 32'd5);
        checkOutput("halt.stay_req", 32'(mem_req), 32'd0);
        applyReset("halt_rst");

        // Undefined opcode 6'h30 halts with sticky illegal flag.
        run = 1'b1; mem_ready = 1'b1; instr_in = I_ILL30;
        tick();
        checkOutput("ill30.dec_pc", 32'(pcControl), 32'd3);
        tick();
        checkOutput("ill30.state", 32'(state), 32'd5);
        checkOutput("ill30.illegal", 32'(illegal), 32'd1);
        checkOutput("ill30.halted", 32'(halted), 32'd1);
        checkOutput("ill30.pcControl", 32'(pcControl), 32'd3);
        tick();
        checkOutput("ill30.sticky", 32'(illegal), 32'd1);
        applyReset("ill30_rst");

        // 6'h0C sits just past the reg-reg ALU range.
        run = 1'b1; mem_ready = 1'b1; instr_in = I_ILL0C;
        tick();
        tick();
        checkOutput("ill0c.state", 32'(state), 32'd5);
        checkOutput("ill0c.illegal", 32'(illegal), 32'd1);
        applyReset("ill0c_rst");

        // Fetch with mem_ready stuck low: bus error after four request cycles.
        run = 1'b1; mem_ready = 1'b0; instr_in = I_ADD;
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput($sformatf("tmo%0d.state", k), 32'(state), 32'd0);
            checkOutput($sformatf("tmo%0d.mem_req", k), 32'(mem_req), 32'd1);
            checkOutput($sformatf("tmo%0d.bus_error", k), 32'(bus_error), 32'd0);
            tick();
        end
        checkOutput("tmo.state", 32'(state), 32'd5);
        checkOutput("tmo.bus_error", 32'(bus_error), 32'd1);
        checkOutput("tmo.halted", 32'(halted), 32'd1);
        checkOutput("tmo.mem_req", 32'(mem_req), 32'd0);
        repeat (2) tick();
        checkOutput("tmo.sticky", 32'(bus_error), 32'd1);
        checkOutput("tmo.req_after", 32'(mem_req), 32'd0);
        applyReset("tmo_rst");

        // Reset lands while a LOAD is waiting in MEM.
        run = 1'b1; mem_ready = 1'b1; instr_in = I_LOAD;
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        checkOutput("mrst.mem_state", 32'(state), 32'd3);
        checkOutput("mrst.mem_req", 32'(mem_req), 32'd1);
        tick();
        checkOutput("mrst.wait_state", 32'(state), 32'd3);
        applyReset("mrst");
        tick();
        checkOutput("mrst.idle_state", 32'(state), 32'd0);
        checkOutput("mrst.idle_req", 32'(mem_req), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle controller that sequences the single-issue CPU datapath. It fetches each 32-bit instruction over the shared RAM port, decodes it, and drives the datapath's control inputs for one instruction at a time: `opcode`, `alucode`, register selects, `imControl`, `regenable`, `ramenable`, `pcControl` and `writecode`. It also owns the RAM handshake for both instruction and data accesses, guards that handshake with a timeout, and halts on `HALT`, on an illegal opcode or on a bus error.

## Interface
- `MEM_TIMEOUT`, default 15: maximum cycles a RAM request may wait for `mem_ready` before a bus error; range 1..255.
- `clock` in 1: processor clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `run` in 1: when 0, the controller does not start a new fetch.
- `mem_ready` in 1: RAM has completed the current request this cycle.
- `instr_in` in 32: RAM read data; captured into the instruction register (IR) on a completed fetch.
- `mem_req` out 1: RAM request valid.
- `mem_we` out 1: request is a write.
- `mem_sel` out 1: address source; 0 = PC (fetch), 1 = data address from `imm`.
- `opcode` out 6: IR[31:26].
- `op1` out 5: IR[25:21].
- `op2` out 5: IR[20:16].
- `imm` out 16: IR[15:0].
- `alucode` out 5: ALU operation select.
- `imControl` out 1: ALU operand 2 source; 1 = `imm`, 0 = register.
- `regenable` out 1: register write enable.
- `ramenable` out 1: datapath RAM address enable.
- `pcControl` out 2: PC action; 0 = +1, 1 = branch-if-equal, 2 = jump to `imm`, 3 = hold.
- `writecode` out 2: register write source; 0 = ALU, 1 = memory, 2 = `imm`.
- `halted` out 1: controller is in HALT.
- `illegal` out 1: sticky; set when an undefined opcode is decoded.
- `bus_error` out 1: sticky; set when a RAM request times out.
- `state` out 3: current state, for debug.

## Operation
- States: FETCH = 0, DECODE = 1, EXECUTE = 2, MEM = 3, WRITEBACK = 4, HALT = 5. Values 6 and 7 go to HALT.
- Outputs are Moore: a function of state and IR only, never of `mem_ready`.
- Default values in every state: `pcControl` = 3; all other controls 0.
- **FETCH**
  - If `run` = 0: idle, `mem_req` = 0, timeout counter cleared.
  - If `run` = 1: `mem_req` = 1, `mem_sel` = 0.
  - On an edge with `mem_ready` = 1: IR <= `instr_in`, go to DECODE.
- **DECODE**: one cycle. Classify the opcode:
  - 6'h00..6'h0B: ALU reg-reg. `alucode` = opcode[3:0], `imControl` = 0.
  - 6'h10..6'h1B: ALU immediate. `alucode` = opcode[3:0], `imControl` = 1.
  - 6'h20 LOAD, 6'h21 STORE, 6'h22 BEQ, 6'h23 JUMP, 6'h24 LOADI, 6'h3F HALT.
  - Anything else: set `illegal`, go to HALT.
- `alucode` and `imControl` stay valid from DECODE through WRITEBACK.
- **EXECUTE**: one cycle.
  - BEQ: `pcControl` = 1, then FETCH.
  - JUMP: `pcControl` = 2, then FETCH.
  - LOAD and STORE: go to MEM.
  - All others: go to WRITEBACK.
- **MEM**: `mem_req` = 1, `mem_sel` = 1, `ramenable` = 1, `mem_we` = 1 for STORE only. Stays until `mem_ready`, then WRITEBACK.
- **WRITEBACK**: one cycle, `pcControl` = 0, then FETCH.
  - ALU: `regenable` = 1, `writecode` = 0.
  - LOAD: `regenable` = 1, `writecode` = 1.
  - LOADI: `regenable` = 1, `writecode` = 2.
  - STORE: `regenable` = 0.
- **HALT**: `halted` = 1, `pcControl` = 3. Terminal until `reset`.
- HALT opcode takes the path DECODE -> HALT, with no PC advance.
- Timeout counter:
  - 8 bits; increments each cycle `mem_req` = 1 and `mem_ready` = 0; clears on completion or on leaving the state.
  - When it reaches `MEM_TIMEOUT` with `mem_ready` still 0: set `bus_error`, go to HALT.
  - `mem_ready` = 1 on that same edge wins: the request completes, no error.
- PC changes exactly once per instruction (WRITEBACK or EXECUTE), except in HALT and on illegal opcodes.

## Timing
- Reset values: state = FETCH, IR = 0, counter = 0, `illegal` = `bus_error` = `halted` = 0, `pcControl` = 3, all other outputs 0.
- `reset` overrides everything, including mid-request: `mem_req` is 0 the cycle after the reset edge.
- Minimum latency with zero-wait RAM (`mem_ready` high the first request cycle):
  - ALU, LOADI, NOP-class: 4 cycles.
  - BEQ, JUMP: 3 cycles.
  - LOAD, STORE: 5 cycles.
- Each RAM wait cycle adds 1 cycle.
- `mem_req` stays high continuously from the first request cycle through the cycle `mem_ready` is sampled, and drops the following cycle.
- `run` is sampled only in FETCH with no request outstanding. Deasserting `run` mid-request does not abort the request.

## Test plan
- Reset, then `run` = 1, `mem_ready` = 1, `instr_in` = 32'h0422_0000 (ADD r1, r2):
  - States 0, 1, 2, 4; `alucode` = 1, `imControl` = 0.
  - WRITEBACK has `regenable` = 1, `writecode` = 0, `pcControl` = 0.
  - `pcControl` = 3 in all other cycles.
- LOAD 6'h20 with `mem_ready` held low for 3 MEM cycles:
  - MEM lasts 4 cycles with `mem_sel` = 1, `ramenable` = 1, `mem_we` = 0.
  - Then WRITEBACK with `writecode` = 1; 8 cycles total.
- BEQ: `pcControl` = 1 for exactly one cycle (EXECUTE), `regenable` never asserted, back to FETCH after 3 cycles.
- `MEM_TIMEOUT` = 4, `mem_ready` tied low:
  - `bus_error` = 1 and `halted` = 1 after 4 request cycles.
  - `mem_req` = 0 afterwards; status persists until `reset`.
- Opcode 6'h30: `illegal` = 1, state = 5, no PC change.
- Assert `reset` during MEM wait: next cycle state = 0, `mem_req` = 0, sticky flags cleared.
